// File: rtl/array_div.sv
// Sequential restoring divider for hidden-bit significands: q = floor(Ma*2^(QW-2)/Mb)
// with a sticky remainder flag, one quotient bit per cycle, plus zero/divide-by-zero fast paths.
module array_div #(
  parameter int unsigned SW = 10,
  parameter int unsigned QW = 24
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          azero,
  input  logic          bzero,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] q,
  output logic          sticky,
  output logic          dbz
);

  localparam int unsigned RW = SW + 3;
  localparam int unsigned CW = $clog2(QW);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW:0]   mb_q, mb_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [QW-1:0] q_q, q_d;
  logic          sticky_q, sticky_d;
  logic          dbz_q, dbz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [RW:0]   diff;
  logic          ge;
  logic [RW-1:0] rem_base;

  // The divisor is compared doubled so QW steps yield exactly QW-2 fraction
  // bits with the quotient MSB always 0; the remainder is held at twice scale.
  always_comb begin
    diff     = {1'b0, rem_q} - {2'b00, mb_q, 1'b0};
    ge       = ~diff[RW];
    rem_base = ge ? diff[RW-1:0] : rem_q;

    state_d  = state_q;
    count_d  = count_q;
    mb_d     = mb_q;
    rem_d    = rem_q;
    q_d      = q_q;
    sticky_d = sticky_q;
    dbz_d    = dbz_q;
    busy_d   = (state_q == CALC);
    done_d   = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (start) begin
          mb_d     = {1'b1, b};
          sticky_d = 1'b0;
          dbz_d    = 1'b0;
          if (bzero) begin
            q_d     = '1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else if (azero) begin
            q_d     = '0;
            state_d = DONE;
          end else begin
            q_d     = '0;
            rem_d   = {2'b00, 1'b1, a};
            count_d = CW'(QW - 1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        q_d   = {q_q[QW-2:0], ge};
        rem_d = rem_base << 1;
        if (count_q == '0) begin
          sticky_d = (rem_base != '0);
          state_d  = DONE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mb_q     <= '0;
      rem_q    <= '0;
      q_q      <= '0;
      sticky_q <= 1'b0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mb_q     <= mb_d;
      rem_q    <= rem_d;
      q_q      <= q_d;
      sticky_q <= sticky_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign q      = q_q;
  assign sticky = sticky_q;
  assign dbz    = dbz_q;

endmodule

// File: tb/tb_array_div.sv
// Directed bench for array_div: hand-computed quotients, fast paths, abort,
// ignored start, and an operand sweep against a reference quotient formula.
module tb_array_div;

  logic        CLK = 1'b0;
  logic        RST, start, azero, bzero;
  logic [9:0]  a, b;
  logic        busy, done, sticky, dbz;
  logic [23:0] q;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 CLK = ~CLK;

  array_div #(.SW(10), .QW(24)) dut (
    .CLK(CLK), .RST(RST), .start(start), .a(a), .b(b),
    .azero(azero), .bzero(bzero), .busy(busy), .done(done),
    .q(q), .sticky(sticky), .dbz(dbz)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Launch one operation, scramble the inputs after acceptance, optionally
  // poke start mid-calculation, then check latency, busy cycles and results.
  task automatic run_op(input string tag, input logic [9:0] ta, input logic [9:0] tb,
                        input logic taz, input logic tbz, input logic [23:0] eq,
                        input logic es, input logic ed, input int elat, input bit poke);
    int lat = 0;
    int busy_cnt = 0;
    a = ta; b = tb; azero = taz; bzero = tbz; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; a = ~ta; b = ~tb; azero = ~taz; bzero = ~tbz;
    for (int k = 1; k <= 40; k++) begin
      if (poke && k == 5) start = 1'b1;
      if (poke && k == 6) start = 1'b0;
      @(posedge CLK); #1;
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"},    lat, elat);
    check({tag, "_busy"},   busy_cnt, (elat > 1) ? elat - 1 : 0);
    check({tag, "_q"},      {8'h0, q}, {8'h0, eq});
    check({tag, "_sticky"}, {31'h0, sticky}, {31'h0, es});
    check({tag, "_dbz"},    {31'h0, dbz}, {31'h0, ed});
    @(posedge CLK); #1;
    check({tag, "_pulse"},  {31'h0, done}, 32'h0);
    check({tag, "_hold"},   {8'h0, q}, {8'h0, eq});
  endtask

  initial begin
    logic [63:0] num, mq;
    logic        ms;
    int          seen_done;
    logic [9:0]  sa, sb;

    RST = 1'b1; start = 1'b0; a = '0; b = '0; azero = 1'b0; bzero = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy",   {31'h0, busy},   32'h0);
    check("rst_done",   {31'h0, done},   32'h0);
    check("rst_q",      {8'h0, q},       32'h0);
    check("rst_sticky", {31'h0, sticky}, 32'h0);
    check("rst_dbz",    {31'h0, dbz},    32'h0);
    RST = 1'b0;
    @(posedge CLK); #1;

    run_op("one_one",     10'h000, 10'h000, 1'b0, 1'b0, 24'h400000, 1'b0, 1'b0, 25, 1'b0);
    run_op("1p5_one",     10'h200, 10'h000, 1'b0, 1'b0, 24'h600000, 1'b0, 1'b0, 25, 1'b0);
    run_op("one_1p5",     10'h000, 10'h200, 1'b0, 1'b0, 24'h2AAAAA, 1'b1, 1'b0, 25, 1'b0);
    run_op("max_max",     10'h3FF, 10'h3FF, 1'b0, 1'b0, 24'h400000, 1'b0, 1'b0, 25, 1'b0);
    run_op("dbz",         10'h123, 10'h055, 1'b0, 1'b1, 24'hFFFFFF, 1'b0, 1'b1, 1,  1'b0);
    run_op("dbz_az",      10'h000, 10'h000, 1'b1, 1'b1, 24'hFFFFFF, 1'b0, 1'b1, 1,  1'b0);
    run_op("azero",       10'h2A5, 10'h1C3, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1,  1'b0);
    run_op("poke_busy",   10'h200, 10'h000, 1'b0, 1'b0, 24'h600000, 1'b0, 1'b0, 25, 1'b1);

    // Abort 10 cycles into a calculation.
    a = 10'h000; b = 10'h200; azero = 1'b0; bzero = 1'b0; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("abort_busy",   {31'h0, busy},   32'h0);
    check("abort_done",   {31'h0, done},   32'h0);
    check("abort_q",      {8'h0, q},       32'h0);
    check("abort_sticky", {31'h0, sticky}, 32'h0);
    check("abort_dbz",    {31'h0, dbz},    32'h0);
    seen_done = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge CLK); #1;
      if (done) seen_done++;
    end
    check("abort_nodone", seen_done, 0);
    run_op("after_abort", 10'h000, 10'h200, 1'b0, 1'b0, 24'h2AAAAA, 1'b1, 1'b0, 25, 1'b0);

    sa = 10'h0F0;
    sb = 10'h3F0;
    for (int i = 0; i < 6; i++) begin
      num = 64'(11'h400 + {1'b0, sa}) << 22;
      mq  = num / 64'(11'h400 + {1'b0, sb});
      ms  = (num % 64'(11'h400 + {1'b0, sb})) != 0;
      run_op($sformatf("sweep%0d", i), sa, sb, 1'b0, 1'b0, mq[23:0], ms, 1'b0, 25, 1'b0);
      sa = sa + 10'd1;
      sb = sb + 10'd2;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
